// File: rtl/alu_pkg.sv
// Shared opcode and FSM state encodings for the multicycle ALU.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLL = 3'b101,
    OP_SRL = 3'b110,
    OP_MUL = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIN  = 2'b10
  } alu_state_e;

  function automatic logic is_shift(alu_op_e op);
    return (op == OP_SLL) || (op == OP_SRL);
  endfunction

endpackage

// File: rtl/alu_addsub.sv
// Combinational adder/subtractor: sum, carry (no-borrow for SUB) and signed overflow.
module alu_addsub #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             c,
  output logic             v
);

  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   full;

  // SUB is A + ~B + 1, so the carry out doubles as the "no borrow" flag.
  assign bx   = sub ? ~b : b;
  assign full = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, sub};
  assign sum  = full[WIDTH-1:0];
  assign c    = full[WIDTH];
  assign v    = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu_multicycle.sv
// Multicycle ALU: single-cycle add/sub/logic, bit-serial shifts, shift-add multiply.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [2:0]       ALU_CTRL,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] ALU_OUT,
  output logic             N,
  output logic             Z,
  output logic             C,
  output logic             V
);

  localparam int CW = SHW + 1;

  alu_state_e       state, state_nxt;
  alu_op_e          op_q, op_in;
  logic [WIDTH-1:0] a_q, b_q, hi_q, lo_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH-1:0] hi_nxt, lo_nxt, res;
  logic [CW-1:0]    cnt_nxt;
  logic [WIDTH:0]   madd;
  logic             last, res_c, res_v;
  logic [WIDTH-1:0] as_sum;
  logic             as_c, as_v;

  assign op_in = alu_op_e'(ALU_CTRL);

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a  (a_q),
    .b  (b_q),
    .sub(op_q == OP_SUB),
    .sum(as_sum),
    .c  (as_c),
    .v  (as_v)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    hi_nxt    = hi_q;
    lo_nxt    = lo_q;
    cnt_nxt   = cnt_q;
    res       = lo_q;
    res_c     = 1'b0;
    res_v     = 1'b0;
    last      = 1'b0;
    madd      = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);

    case (op_q)
      OP_ADD, OP_SUB: begin
        res   = as_sum;
        res_c = as_c;
        res_v = as_v;
        last  = 1'b1;
      end
      OP_AND: begin res = a_q & b_q; last = 1'b1; end
      OP_OR:  begin res = a_q | b_q; last = 1'b1; end
      OP_XOR: begin res = a_q ^ b_q; last = 1'b1; end
      OP_SLL, OP_SRL: begin
        if (cnt_q == '0) begin
          last = 1'b1;
        end else begin
          if (op_q == OP_SLL) begin
            lo_nxt = {lo_q[WIDTH-2:0], 1'b0};
            res_c  = lo_q[WIDTH-1];
          end else begin
            lo_nxt = {1'b0, lo_q[WIDTH-1:1]};
            res_c  = lo_q[0];
          end
          res     = lo_nxt;
          cnt_nxt = cnt_q - 1'b1;
          last    = (cnt_q == CW'(1));
        end
      end
      OP_MUL: begin
        // {hi, lo} holds partial product above the not-yet-consumed multiplier bits.
        hi_nxt  = madd[WIDTH:1];
        lo_nxt  = {madd[0], lo_q[WIDTH-1:1]};
        res     = lo_nxt;
        res_c   = |hi_nxt;
        cnt_nxt = cnt_q - 1'b1;
        last    = (cnt_q == CW'(1));
      end
      default: ;
    endcase

    case (state)
      S_IDLE:  if (START) state_nxt = S_RUN;
      S_RUN:   if (last)  state_nxt = S_FIN;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: every datapath register is reset so an abandoned operation leaves nothing behind.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      ALU_OUT <= '0;
      N       <= 1'b0;
      Z       <= 1'b0;
      C       <= 1'b0;
      V       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (START) begin
          op_q  <= op_in;
          a_q   <= A;
          b_q   <= B;
          hi_q  <= '0;
          lo_q  <= (op_in == OP_MUL) ? B : A;
          if (is_shift(op_in))     cnt_q <= CW'(B[SHW-1:0]);
          else if (op_in == OP_MUL) cnt_q <= CW'(WIDTH);
          else                     cnt_q <= '0;
        end
        S_RUN: begin
          hi_q  <= hi_nxt;
          lo_q  <= lo_nxt;
          cnt_q <= cnt_nxt;
          if (last) begin
            ALU_OUT <= res;
            N       <= res[WIDTH-1];
            Z       <= (res == '0);
            C       <= res_c;
            V       <= res_v;
          end
        end
        default: ;
      endcase
    end
  end

  assign BUSY = (state == S_RUN) || (state == S_FIN);
  assign DONE = (state == S_FIN);

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle at WIDTH=16 with hand-computed results, flags and latencies.
module tb_alu_multicycle;

  localparam int W = 16;

  logic         CLK, RST_N, START;
  logic [2:0]   ALU_CTRL;
  logic [W-1:0] A, B;
  logic         BUSY, DONE, N, Z, C, V;
  logic [W-1:0] ALU_OUT;

  int checks = 0;
  int errors = 0;

  alu_multicycle #(.WIDTH(W)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .ALU_CTRL(ALU_CTRL),
    .A(A), .B(B), .BUSY(BUSY), .DONE(DONE), .ALU_OUT(ALU_OUT),
    .N(N), .Z(Z), .C(C), .V(V)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Drives one request, scrambles inputs after acceptance, waits (bounded) for DONE.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] out, output logic [3:0] nzcv, output int lat);
    @(negedge CLK);
    ALU_CTRL = op; A = a; B = b; START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0; ALU_CTRL = ~op; A = ~a; B = ~b;
    lat = 0;
    do begin
      @(negedge CLK);
      lat++;
    end while (!DONE && lat < 64);
    out  = ALU_OUT;
    nzcv = {N, Z, C, V};
  endtask

  task automatic test_reset;
    RST_N = 1'b0; START = 1'b0; ALU_CTRL = 3'b000; A = '0; B = '0;
    repeat (3) @(negedge CLK);
    checks++;
    if ({BUSY, DONE, ALU_OUT, N, Z, C, V} !== '0) begin
      errors++;
      $display("FAIL reset_state got busy=%b done=%b out=%h nzcv=%b%b%b%b want all 0",
               BUSY, DONE, ALU_OUT, N, Z, C, V);
    end
    RST_N = 1'b1;
  endtask

  // Vector table: op, a, b, expected out, expected NZCV, expected DONE latency.
  typedef struct {
    string        name;
    logic [2:0]   op;
    logic [W-1:0] a, b, out;
    logic [3:0]   nzcv;
    int           lat;
  } vec_t;

  task automatic apply(input vec_t t);
    logic [W-1:0] out;
    logic [3:0]   f;
    int           lat;
    run_op(t.op, t.a, t.b, out, f, lat);
    checks++;
    if (lat !== t.lat || !DONE) begin
      errors++;
      $display("FAIL %s_latency got %0d want %0d", t.name, lat, t.lat);
    end
    checks++;
    if (out !== t.out) begin
      errors++;
      $display("FAIL %s_out got %h want %h", t.name, out, t.out);
    end
    checks++;
    if (f !== t.nzcv) begin
      errors++;
      $display("FAIL %s_nzcv got %b want %b", t.name, f, t.nzcv);
    end
  endtask

  task automatic test_addsub;
    vec_t v[5];
    v[0] = '{"add_ovf",  3'b000, 16'h7FFF, 16'h0001, 16'h8000, 4'b1001, 2};
    v[1] = '{"add_carry",3'b000, 16'hFFFF, 16'h0001, 16'h0000, 4'b0110, 2};
    v[2] = '{"sub_borrow",3'b001,16'h0000, 16'h0001, 16'hFFFF, 4'b1000, 2};
    v[3] = '{"sub_equal",3'b001, 16'h0625, 16'h0625, 16'h0000, 4'b0110, 2};
    v[4] = '{"sub_ovf",  3'b001, 16'h8000, 16'h0001, 16'h7FFF, 4'b0011, 2};
    foreach (v[i]) apply(v[i]);
  endtask

  task automatic test_logic;
    vec_t v[3];
    v[0] = '{"xor",  3'b100, 16'hFF00, 16'h0FF0, 16'hF0F0, 4'b1000, 2};
    v[1] = '{"or_z", 3'b011, 16'h0000, 16'h0000, 16'h0000, 4'b0100, 2};
    v[2] = '{"and",  3'b010, 16'hF0F0, 16'h3C3C, 16'h3030, 4'b0000, 2};
    foreach (v[i]) apply(v[i]);
  endtask

  task automatic test_shift;
    vec_t v[4];
    v[0] = '{"srl_2",  3'b110, 16'h000F, 16'h0002, 16'h0003, 4'b0010, 3};
    v[1] = '{"sll_0",  3'b101, 16'h8001, 16'h0010, 16'h8001, 4'b1000, 2};
    v[2] = '{"sll_1",  3'b101, 16'h8001, 16'h0001, 16'h0002, 4'b0010, 2};
    v[3] = '{"srl_15", 3'b110, 16'h8000, 16'h000F, 16'h0001, 4'b0000, 16};
    foreach (v[i]) apply(v[i]);
  endtask

  task automatic test_mul;
    vec_t v[3];
    v[0] = '{"mul_small", 3'b111, 16'h00FF, 16'h0003, 16'h02FD, 4'b0000, 17};
    v[1] = '{"mul_wrap",  3'b111, 16'h0100, 16'h0100, 16'h0000, 4'b0110, 17};
    v[2] = '{"mul_max",   3'b111, 16'hFFFF, 16'hFFFF, 16'h0001, 4'b0010, 17};
    foreach (v[i]) apply(v[i]);
  endtask

  // START pulses during RUN and during DONE must be dropped, not queued.
  task automatic test_back_to_back;
    int  lat;
    int  extra;
    vec_t t;
    @(negedge CLK);
    ALU_CTRL = 3'b111; A = 16'h0012; B = 16'h0034; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    lat = 1;
    while (!DONE && lat < 64) begin
      if (lat == 5) begin
        ALU_CTRL = 3'b100; A = 16'hAAAA; B = 16'h5555; START = 1'b1;
      end else begin
        START = 1'b0;
      end
      @(negedge CLK);
      lat++;
    end
    checks++;
    if (lat !== 17) begin
      errors++;
      $display("FAIL busy_mul_latency got %0d want 17", lat);
    end
    checks++;
    if ({ALU_OUT, N, Z, C, V} !== {16'h03A8, 4'b0000}) begin
      errors++;
      $display("FAIL busy_mul_result got %h/%b%b%b%b want 03a8/0000", ALU_OUT, N, Z, C, V);
    end
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    extra = 0;
    repeat (20) begin
      @(negedge CLK);
      if (DONE || BUSY) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL start_not_queued got %0d busy/done cycles want 0", extra);
    end
    t = '{"after_ignored", 3'b000, 16'h0001, 16'h0002, 16'h0003, 4'b0000, 2};
    apply(t);
  endtask

  task automatic test_reset_mid;
    int   seen;
    vec_t t;
    @(negedge CLK);
    ALU_CTRL = 3'b111; A = 16'h1234; B = 16'h5678; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (7) @(negedge CLK);
    #2 RST_N = 1'b0;
    #1;
    checks++;
    if ({BUSY, DONE, ALU_OUT, N, Z, C, V} !== '0) begin
      errors++;
      $display("FAIL async_reset got busy=%b done=%b out=%h nzcv=%b%b%b%b want all 0",
               BUSY, DONE, ALU_OUT, N, Z, C, V);
    end
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    seen = 0;
    repeat (25) begin
      @(negedge CLK);
      if (DONE || BUSY) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL abandoned_op got %0d busy/done cycles want 0", seen);
    end
    t = '{"and_after_rst", 3'b010, 16'h0F0F, 16'h00FF, 16'h000F, 4'b0000, 2};
    apply(t);
  endtask

  initial begin
    test_reset;
    test_addsub;
    test_logic;
    test_shift;
    test_mul;
    test_back_to_back;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
